ysyx_23060077_riscv_wbu: RTL and testbench
==========================================

# ysyx_23060077_riscv_wbu

Write-back unit for the ysyx_23060077 RISC-V core: the writer side of the GPR regfile write port. Accepts completed results from the EXU (ALU/CSR/jump link) and LSU (loads) over valid/ready handshakes, arbitrates them into one registered write per cycle on `rd_en`/`rd_addr`/`rd_data`, and keeps a per-register pending-write scoreboard that the IDU queries for RAW hazards before issue. Sits between EXU/LSU and the regfile.

## Interface
- `DATA_WIDTH`, 32, GPR data width.
- `REG_WIDTH`, 5, GPR index width.
- `REG_COUNT`, 32, number of GPRs; x0 is hardwired zero.

- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `exu_valid`  in  1  EXU result valid.
- `exu_ready`  out  1  WBU accepts EXU result this cycle.
- `exu_rd_en`  in  1  EXU result writes a GPR.
- `exu_rd_addr`  in  REG_WIDTH  EXU destination.
- `exu_rd_data`  in  DATA_WIDTH  EXU result.
- `lsu_valid`  in  1  LSU result valid.
- `lsu_ready`  out  1  WBU accepts LSU result this cycle.
- `lsu_rd_en`  in  1  LSU result writes a GPR.
- `lsu_rd_addr`  in  REG_WIDTH  LSU destination.
- `lsu_rd_data`  in  DATA_WIDTH  load data.
- `issue_valid`  in  1  IDU issuing an instruction this cycle.
- `issue_rd_en`  in  1  issued instruction writes a GPR.
- `issue_rd_addr`  in  REG_WIDTH  issued destination.
- `issue_ready`  out  1  scoreboard can record the issue.
- `rs1_addr`, `rs2_addr`  in  REG_WIDTH  hazard query indices.
- `rs1_busy`, `rs2_busy`  out  1  queried register has a pending write.
- `rd_en`  out  1  regfile write enable (registered).
- `rd_addr`  out  REG_WIDTH  regfile write index (registered).
- `rd_data`  out  DATA_WIDTH  regfile write data (registered).
- `wb_retire`  out  1  one instruction retired this cycle (registered).
- `retire_cnt`  out  32  retired-instruction counter.

## Operation
- Arbitration: fixed priority, LSU over EXU. `lsu_ready` = 1 always; `exu_ready` = !`lsu_valid`. Accept = valid && ready; at most one accept per cycle.
- Output stage: on accept, next edge loads `rd_addr`/`rd_data` from winner, `rd_en` = winner's rd_en && addr != 0, `wb_retire` = 1. No accept: `rd_en` = 0, `wb_retire` = 0, `rd_addr`/`rd_data` hold.
- Results with rd_en=0 or addr 0 still retire but never write.
- Scoreboard: 2-bit pending counter per register 1..REG_COUNT-1; x0 counter constant 0.
  - inc: `issue_valid && issue_ready && issue_rd_en && issue_rd_addr != 0`.
  - dec: `rd_en` output high, on `rd_addr` (same edge the regfile stores the data).
  - inc and dec same register same cycle: no change.
  - `issue_ready` = 0 when `issue_rd_en` and counter[`issue_rd_addr`] == 3; else 1.
  - `rsN_busy` = counter[`rsN_addr`] != 0, combinational; always 0 for x0.
- `retire_cnt` increments by 1 each cycle `wb_retire` is high; wraps 0xFFFFFFFF -> 0.
- Decrement of a zero counter is a protocol violation; flag with a simulation assertion, counter saturates at 0.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `rd_data`=0, `wb_retire`=0, `retire_cnt`=0, all counters 0; `exu_ready`/`lsu_ready`/`issue_ready`=1, `rsN_busy`=0 during reset.
- Latency: accept in cycle N -> `rd_en` high in cycle N+1 -> regfile and scoreboard updated at end of N+1; `rsN_busy` drops in N+2.
- Throughput: one result per cycle; EXU starves only while LSU valid every cycle.
- EXU must hold valid/data stable while `exu_ready`=0.
- Reset mid-operation: registered write dropped, scoreboard cleared; upstream flushes with it.

## Test plan
- Reset then single EXU result x5=0x1234_5678 -> next cycle `rd_en`=1, `rd_addr`=5, `rd_data`=0x12345678, `wb_retire`=1, `retire_cnt`=1.
- EXU (x3=0xA) and LSU (x4=0xB) valid same cycle -> LSU written cycle N+1, `exu_ready`=0 in N; EXU written N+2; `retire_cnt`=2.
- Issue to x7, query rs1=7 -> `rs1_busy`=1 until result for x7 written; 0 the cycle after `rd_en` with `rd_addr`=7.
- Three issues to x9 without writeback -> fourth sees `issue_ready`=0; one writeback of x9 -> `issue_ready`=1.
- EXU result to x0 data 0xFFFF_FFFF -> `rd_en`=0, `wb_retire`=1; `rs1_busy` for rs1=0 always 0.
- Assert `rst` with write pending and x2 counter 2 -> `rd_en`=0 immediately, `rs1_busy`(x2)=0, `retire_cnt`=0.

Source files
------------

// File: rtl/ysyx_23060077_riscv_wbu.sv
// Write-back unit: arbitrates LSU/EXU results into one registered GPR write per cycle
// and tracks pending writes per register for the IDU's RAW-hazard checks.
module ysyx_23060077_riscv_wbu #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_WIDTH  = 5,
   parameter int REG_COUNT  = 32
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  exu_valid,
   output logic                  exu_ready,
   input  logic                  exu_rd_en,
   input  logic [REG_WIDTH-1:0]  exu_rd_addr,
   input  logic [DATA_WIDTH-1:0] exu_rd_data,

   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic                  lsu_rd_en,
   input  logic [REG_WIDTH-1:0]  lsu_rd_addr,
   input  logic [DATA_WIDTH-1:0] lsu_rd_data,

   input  logic                  issue_valid,
   input  logic                  issue_rd_en,
   input  logic [REG_WIDTH-1:0]  issue_rd_addr,
   output logic                  issue_ready,

   input  logic [REG_WIDTH-1:0]  rs1_addr,
   input  logic [REG_WIDTH-1:0]  rs2_addr,
   output logic                  rs1_busy,
   output logic                  rs2_busy,

   output logic                  rd_en,
   output logic [REG_WIDTH-1:0]  rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  wb_retire,
   output logic [31:0]           retire_cnt
);

   typedef logic [1:0] pend_t;

   pend_t                 pend [REG_COUNT];
   logic                  lsu_fire;
   logic                  exu_fire;
   logic                  any_fire;
   logic                  win_en;
   logic [REG_WIDTH-1:0]  win_addr;
   logic [DATA_WIDTH-1:0] win_data;
   logic                  issue_fire;
   logic [REG_COUNT-1:0]  inc_vec;
   logic [REG_COUNT-1:0]  dec_vec;
   logic                  dec_idle;

   // LSU always wins; EXU is told to hold while a load result is present.
   assign lsu_ready = 1'b1;
   assign exu_ready = rst | ~lsu_valid;
   assign lsu_fire  = lsu_valid;
   assign exu_fire  = exu_valid & ~lsu_valid;
   assign any_fire  = lsu_fire | exu_fire;

   always_comb begin
      // NOTE: every variable gets a default before the branch, so no path leaves it unassigned and no latch is inferred.
      win_en   = exu_rd_en;
      win_addr = exu_rd_addr;
      win_data = exu_rd_data;
      if (lsu_fire) begin
         win_en   = lsu_rd_en;
         win_addr = lsu_rd_addr;
         win_data = lsu_rd_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         rd_data   <= '0;
         wb_retire <= 1'b0;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
         rd_en     <= any_fire & win_en & (win_addr != '0);
         wb_retire <= any_fire;
         if (any_fire) begin
            rd_addr <= win_addr;
            rd_data <= win_data;
         end
      end
   end

   // Counted on accept so the value already includes the instruction wb_retire is flagging.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retire_cnt <= '0;
      end else if (any_fire) begin
         retire_cnt <= retire_cnt + 32'd1;
      end
   end

   assign issue_ready = ~(issue_rd_en && (pend[issue_rd_addr] == 2'd3));
   assign issue_fire  = issue_valid & issue_ready & issue_rd_en & (issue_rd_addr != '0);
   assign rs1_busy    = (pend[rs1_addr] != 2'd0);
   assign rs2_busy    = (pend[rs2_addr] != 2'd0);

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      for (int i = 1; i < REG_COUNT; i++) begin
         if (issue_fire && (issue_rd_addr == REG_WIDTH'(i))) inc_vec[i] = 1'b1;
         if (rd_en && (rd_addr == REG_WIDTH'(i)))             dec_vec[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the counter array is reset explicitly; a stale count would report hazards that no longer exist.
         for (int i = 0; i < REG_COUNT; i++) pend[i] <= '0;
      end else begin
         for (int i = 1; i < REG_COUNT; i++) begin
            case ({inc_vec[i], dec_vec[i]})
               2'b10:   if (pend[i] != 2'd3) pend[i] <= pend[i] + 2'd1;
               2'b01:   if (pend[i] != 2'd0) pend[i] <= pend[i] - 2'd1;
               default: ;
            endcase
         end
      end
   end

   // A write to a register with no recorded issue means upstream broke the protocol.
   assign dec_idle = rd_en && (pend[rd_addr] == 2'd0);

   a_no_dec_idle: assert property (@(posedge clk) disable iff (rst) !dec_idle);

endmodule

// File: tb/tb_ysyx_23060077_riscv_wbu.sv
// Randomized scoreboard bench for the write-back unit: directed scenarios, then random
// issue/complete traffic checked against a per-register pending-count model.
module tb_ysyx_23060077_riscv_wbu;

   typedef struct {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] data;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        exu_valid = 0, exu_rd_en = 0, lsu_valid = 0, lsu_rd_en = 0;
   logic [4:0]  exu_rd_addr = 0, lsu_rd_addr = 0, issue_rd_addr = 0, rs1_addr = 0, rs2_addr = 0;
   logic [31:0] exu_rd_data = 0, lsu_rd_data = 0;
   logic        issue_valid = 0, issue_rd_en = 0;
   logic        exu_ready, lsu_ready, issue_ready, rs1_busy, rs2_busy;
   logic        rd_en, wb_retire;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data, retire_cnt;

   int   checks = 0;
   int   failures = 0;
   int   pend_m [32];
   res_t exp_q [$];
   res_t out_q [$];
   res_t lw;
   logic lw_valid = 1'b0;
   logic lsu_taken, exu_taken, issue_taken;

   logic [31:0] exp_cnt = 0;
   logic [4:0]  last_addr = 0;
   logic [31:0] last_data = 0;

   ysyx_23060077_riscv_wbu dut (
      .clk(clk), .rst(rst),
      .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd_en(exu_rd_en),
      .exu_rd_addr(exu_rd_addr), .exu_rd_data(exu_rd_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd_en(lsu_rd_en),
      .lsu_rd_addr(lsu_rd_addr), .lsu_rd_data(lsu_rd_data),
      .issue_valid(issue_valid), .issue_rd_en(issue_rd_en),
      .issue_rd_addr(issue_rd_addr), .issue_ready(issue_ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .wb_retire(wb_retire), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic logic model_issue_ready();
      return !(issue_rd_en && pend_m[issue_rd_addr] == 3);
   endfunction

   task automatic clear_in();
      exu_valid = 0; exu_rd_en = 0; exu_rd_addr = 0; exu_rd_data = 0;
      lsu_valid = 0; lsu_rd_en = 0; lsu_rd_addr = 0; lsu_rd_data = 0;
      issue_valid = 0; issue_rd_en = 0; issue_rd_addr = 0;
   endtask

   task automatic set_exu(input logic en, input logic [4:0] a, input logic [31:0] d);
      exu_valid = 1; exu_rd_en = en; exu_rd_addr = a; exu_rd_data = d;
   endtask

   task automatic set_lsu(input logic en, input logic [4:0] a, input logic [31:0] d);
      lsu_valid = 1; lsu_rd_en = en; lsu_rd_addr = a; lsu_rd_data = d;
   endtask

   task automatic set_issue(input logic en, input logic [4:0] a);
      issue_valid = 1; issue_rd_en = en; issue_rd_addr = a;
   endtask

   task automatic model_reset();
      exp_q.delete();
      out_q.delete();
      for (int i = 0; i < 32; i++) pend_m[i] = 0;
      lw_valid = 0;
   endtask

   // One clock: check combinational outputs mid-cycle, then apply the model at the edge.
   task automatic tick();
      logic iss_ok;
      res_t r;
      @(negedge clk);
      iss_ok = model_issue_ready();
      check("exu_ready", exu_ready, !lsu_valid);
      check("lsu_ready", lsu_ready, 1'b1);
      check("issue_ready", issue_ready, iss_ok);
      check("rs1_busy", rs1_busy, pend_m[rs1_addr] != 0);
      check("rs2_busy", rs2_busy, pend_m[rs2_addr] != 0);
      @(posedge clk);
      if (lw_valid && lw.en && lw.addr != 0) pend_m[lw.addr]--;
      issue_taken = issue_valid && iss_ok;
      if (issue_taken && issue_rd_en && issue_rd_addr != 0) pend_m[issue_rd_addr]++;
      lsu_taken = lsu_valid;
      exu_taken = exu_valid && !lsu_valid;
      lw_valid  = lsu_taken || exu_taken;
      if (lsu_taken) begin
         r.en = lsu_rd_en; r.addr = lsu_rd_addr; r.data = lsu_rd_data;
      end else begin
         r.en = exu_rd_en; r.addr = exu_rd_addr; r.data = exu_rd_data;
      end
      if (lw_valid) begin
         exp_q.push_back(r);
         lw = r;
      end
      #1;
   endtask

   task automatic take(output res_t r);
      int k;
      k = $urandom_range(0, out_q.size() - 1);
      r = out_q[k];
      out_q.delete(k);
      r.data = $urandom;
   endtask

   task automatic random_refill(input logic allow_issue);
      res_t r;
      if (issue_taken) begin
         r.en = issue_rd_en; r.addr = issue_rd_addr; r.data = 0;
         out_q.push_back(r);
      end
      if (exu_taken) exu_valid = 0;
      lsu_valid = 0;
      if (out_q.size() > 0 && $urandom_range(0, 2) == 0) begin
         take(r);
         set_lsu(r.en, r.addr, r.data);
      end
      if (!exu_valid && out_q.size() > 0 && $urandom_range(0, 1) == 0) begin
         take(r);
         set_exu(r.en, r.addr, r.data);
      end
      issue_valid   = allow_issue && (out_q.size() < 6) && ($urandom_range(0, 1) == 1);
      issue_rd_en   = ($urandom_range(0, 7) != 0);
      issue_rd_addr = 5'($urandom_range(0, 12));
      rs1_addr      = 5'($urandom_range(0, 12));
      rs2_addr      = 5'($urandom_range(0, 12));
   endtask

   // Monitor: pops one expected write per wb_retire pulse, independent of the stimulus.
   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_cnt = 0; last_addr = 0; last_data = 0;
         end else begin
            if (wb_retire) begin
               if (exp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_retire got=1 expected=0 t=%0t", $time);
               end else begin
                  e = exp_q.pop_front();
                  exp_cnt = exp_cnt + 1;
                  last_addr = e.addr; last_data = e.data;
                  check("wb_rd_en", rd_en, e.en && e.addr != 0);
                  check("wb_rd_addr", rd_addr, e.addr);
                  check("wb_rd_data", rd_data, e.data);
               end
            end else begin
               check("idle_rd_en", rd_en, 1'b0);
               check("hold_rd_addr", rd_addr, last_addr);
               check("hold_rd_data", rd_data, last_data);
            end
            check("retire_cnt", retire_cnt, exp_cnt);
         end
      end
   end

   initial begin
      model_reset();
      // Reset state, with an LSU result present to confirm exu_ready is still high.
      lsu_valid = 1;
      #3;
      check("rst_exu_ready", exu_ready, 1'b1);
      check("rst_issue_ready", issue_ready, 1'b1);
      check("rst_rd_en", rd_en, 1'b0);
      check("rst_wb_retire", wb_retire, 1'b0);
      check("rst_retire_cnt", retire_cnt, 32'd0);
      check("rst_rs1_busy", rs1_busy, 1'b0);
      clear_in();
      @(posedge clk); @(posedge clk); #1;
      rst = 0;

      // Single EXU result to x5.
      set_issue(1, 5); tick(); clear_in();
      set_exu(1, 5, 32'h1234_5678); tick(); clear_in();
      check("t1_rd_en", rd_en, 1'b1);
      check("t1_rd_addr", rd_addr, 5'd5);
      check("t1_rd_data", rd_data, 32'h1234_5678);
      check("t1_wb_retire", wb_retire, 1'b1);
      check("t1_retire_cnt", retire_cnt, 32'd1);
      tick();

      // EXU and LSU collide; LSU first, EXU held and written one cycle later.
      set_issue(1, 3); tick();
      set_issue(1, 4); tick(); clear_in();
      set_exu(1, 3, 32'hA); set_lsu(1, 4, 32'hB);
      #1 check("t2_exu_ready", exu_ready, 1'b0);
      tick(); lsu_valid = 0;
      check("t2_lsu_addr", rd_addr, 5'd4);
      check("t2_lsu_data", rd_data, 32'hB);
      tick(); clear_in();
      check("t2_exu_addr", rd_addr, 5'd3);
      check("t2_exu_data", rd_data, 32'hA);
      check("t2_retire_cnt", retire_cnt, 32'd3);

      // Busy window for x7.
      rs1_addr = 7;
      set_issue(1, 7); tick(); clear_in();
      check("t3_busy_after_issue", rs1_busy, 1'b1);
      tick(); tick();
      set_exu(1, 7, 32'h7777); tick(); clear_in();
      check("t3_busy_during_write", rs1_busy, 1'b1);
      tick();
      check("t3_busy_cleared", rs1_busy, 1'b0);

      // Counter saturation on x9.
      for (int i = 0; i < 3; i++) begin set_issue(1, 9); tick(); end
      #1 check("t4_issue_blocked", issue_ready, 1'b0);
      set_exu(1, 9, 32'h9999); tick(); exu_valid = 0;
      check("t4_still_blocked", issue_ready, 1'b0);
      tick();
      check("t4_unblocked", issue_ready, 1'b1);
      tick(); clear_in();

      // Writes to x0 retire but never write.
      rs1_addr = 0;
      set_exu(1, 0, 32'hFFFF_FFFF); set_issue(1, 0); tick(); clear_in();
      check("t5_rd_en", rd_en, 1'b0);
      check("t5_wb_retire", wb_retire, 1'b1);
      check("t5_rs1_busy_x0", rs1_busy, 1'b0);
      tick();

      // Reset with a write in flight and x2 pending twice.
      set_issue(1, 2); tick(); tick();
      set_issue(1, 5); tick(); clear_in();
      set_exu(1, 5, 32'h5555_0000); tick(); clear_in();
      rs1_addr = 2;
      #1 check("t6_pre_busy", rs1_busy, 1'b1);
      rst = 1;
      #1;
      check("t6_rd_en", rd_en, 1'b0);
      check("t6_wb_retire", wb_retire, 1'b0);
      check("t6_rs1_busy", rs1_busy, 1'b0);
      check("t6_retire_cnt", retire_cnt, 32'd0);
      model_reset();
      @(posedge clk); #1;
      rst = 0;

      // Random traffic.
      issue_taken = 0; exu_taken = 0;
      for (int c = 0; c < 1500; c++) begin
         tick();
         random_refill(1'b1);
      end
      for (int c = 0; c < 300; c++) begin
         if (out_q.size() == 0 && !exu_valid && !lsu_valid && !issue_valid) break;
         tick();
         random_refill(1'b0);
      end
      check("drain_left", out_q.size() + int'(exu_valid) + int'(lsu_valid), 0);
      clear_in();
      tick(); tick(); tick();
      for (int i = 1; i < 32; i++) begin
         rs1_addr = 5'(i);
         #1 check("final_busy", rs1_busy, pend_m[i] != 0);
      end
      @(negedge clk); #1;
      check("exp_q_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
